// File: rtl/mole_scheduler.sv
// Whack-a-mole sequencer: IDLE/GAP/SHOW/OVER with a show window that shrinks per level.
// Optional feature macro MOLE_STREAK_BONUS_EN: streak tracking and +2 score on every 4th consecutive hit.
module mole_scheduler #(
  parameter logic [15:0] BASE_WINDOW    = 16'd50000,
  parameter logic [15:0] MIN_WINDOW     = 16'd10000,
  parameter logic [15:0] WINDOW_STEP    = 16'd5000,
  parameter logic [15:0] GAP_CYCLES     = 16'd20000,
  parameter int          HITS_PER_LEVEL = 4,
  parameter int          MAX_MISSES     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic [2:0] rnd,
  input  logic       hit_valid,
  input  logic [2:0] hit_idx,
  output logic       mole_valid,
  output logic [2:0] mole_idx,
  output logic [7:0] score,
  output logic [3:0] level,
  output logic [1:0] misses,
  output logic       game_over,
  output logic       hit_ack,
  output logic       miss_pulse,
  output logic [3:0] streak
);

  typedef enum logic [1:0] {IDLE, GAP, SHOW, OVER} state_t;

  localparam logic [15:0] HIT_LAST  = 16'(HITS_PER_LEVEL - 1);
  // misses value at which one more expiry ends the game
  localparam logic [1:0]  MISS_LAST = 2'(MAX_MISSES - 1);

  state_t      state, state_nxt;
  logic [15:0] gap_cnt, gap_nxt;
  logic [15:0] timer, timer_nxt;
  logic [15:0] window, window_nxt;
  logic [15:0] hit_cnt, hit_cnt_nxt;
  logic [2:0]  idx_nxt, pick;
  logic [7:0]  score_nxt, score_sat;
  logic [8:0]  score_add, score_sum;
  logic [3:0]  level_nxt, streak_nxt;
  logic [1:0]  misses_nxt;
  logic        ack_nxt, miss_nxt;
  logic [15:0] window_dn;
  logic        good_hit;

`ifdef MOLE_STREAK_BONUS_EN
  logic [3:0] streak_inc;
  assign streak_inc = (streak == 4'd15) ? 4'd15 : streak + 4'd1;
  assign score_add  = (streak_inc[1:0] == 2'd0) ? 9'd2 : 9'd1;
`else
  assign score_add  = 9'd1;
`endif

  assign score_sum = {1'b0, score} + score_add;
  assign score_sat = score_sum[8] ? 8'hFF : score_sum[7:0];
  assign good_hit  = hit_valid && (hit_idx == mole_idx);

  // shrink without wrapping below zero, floored at MIN_WINDOW
  assign window_dn = ({1'b0, window} >= ({1'b0, MIN_WINDOW} + {1'b0, WINDOW_STEP}))
                     ? window - WINDOW_STEP : MIN_WINDOW;

  // never repeat the previous segment; 7 is folded onto 0 (or 1 when 0 was just shown)
  always_comb begin
    if (rnd == 3'd7)           pick = (mole_idx != 3'd0) ? 3'd0 : 3'd1;
    else if (rnd == mole_idx)  pick = (rnd == 3'd6) ? 3'd0 : rnd + 3'd1;
    else                       pick = rnd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    gap_nxt     = gap_cnt;
    timer_nxt   = timer;
    window_nxt  = window;
    hit_cnt_nxt = hit_cnt;
    idx_nxt     = mole_idx;
    score_nxt   = score;
    level_nxt   = level;
    misses_nxt  = misses;
    streak_nxt  = streak;
    ack_nxt     = 1'b0;
    miss_nxt    = 1'b0;
    if (!pause) begin
      if (start) begin
        state_nxt   = GAP;
        gap_nxt     = GAP_CYCLES;
        window_nxt  = BASE_WINDOW;
        hit_cnt_nxt = '0;
        score_nxt   = '0;
        level_nxt   = '0;
        misses_nxt  = '0;
        streak_nxt  = '0;
      end else begin
        case (state)
          GAP: begin
            if (gap_cnt <= 16'd1) begin
              state_nxt = SHOW;
              timer_nxt = window;
              idx_nxt   = pick;
            end else begin
              gap_nxt = gap_cnt - 16'd1;
            end
          end
          SHOW: begin
            if (good_hit) begin
              ack_nxt   = 1'b1;
              score_nxt = score_sat;
              state_nxt = GAP;
              gap_nxt   = GAP_CYCLES;
`ifdef MOLE_STREAK_BONUS_EN
              streak_nxt = streak_inc;
`endif
              if (hit_cnt >= HIT_LAST) begin
                hit_cnt_nxt = '0;
                level_nxt   = (level == 4'd15) ? 4'd15 : level + 4'd1;
                window_nxt  = window_dn;
              end else begin
                hit_cnt_nxt = hit_cnt + 16'd1;
              end
            end else if (timer <= 16'd1) begin
              miss_nxt   = 1'b1;
              misses_nxt = misses + 2'd1;
              streak_nxt = '0;
              if (misses >= MISS_LAST) begin
                state_nxt = OVER;
              end else begin
                state_nxt = GAP;
                gap_nxt   = GAP_CYCLES;
              end
            end else begin
              timer_nxt = timer - 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt    <= '0;
      timer      <= '0;
      window     <= BASE_WINDOW;
      hit_cnt    <= '0;
      mole_idx   <= '0;
      score      <= '0;
      level      <= '0;
      misses     <= '0;
      streak     <= '0;
      hit_ack    <= 1'b0;
      miss_pulse <= 1'b0;
      mole_valid <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      gap_cnt    <= gap_nxt;
      timer      <= timer_nxt;
      window     <= window_nxt;
      hit_cnt    <= hit_cnt_nxt;
      mole_idx   <= idx_nxt;
      score      <= score_nxt;
      level      <= level_nxt;
      misses     <= misses_nxt;
      streak     <= streak_nxt;
      hit_ack    <= ack_nxt;
      miss_pulse <= miss_nxt;
      mole_valid <= (state_nxt == SHOW);
      game_over  <= (state_nxt == OVER);
    end
  end

endmodule
